pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Control side of the pipeline registers: drives the en/flush inputs of PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
//  Detects load-use hazards in ID, redirects on taken branch/jump from EX, and freezes the pipe on data-memory wait.
//  Includes a wait-timeout FSM and saturating stall/flush performance counters. Sits beside the 5-stage datapath.
// PARAMETERS
//  REG_AW    5   register-index width
//  CNT_W     32  width of stall_cycles / flush_count
//  MAX_WAIT  16  max consecutive mem_busy cycles tolerated (>=1)
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  id_rs1        in   REG_AW  rs1 of instruction in ID
//  id_rs2        in   REG_AW  rs2 of instruction in ID
//  id_rs1_used   in   1       ID instruction reads rs1
//  id_rs2_used   in   1       ID instruction reads rs2
//  ex_rd         in   REG_AW  rd of instruction in EX
//  ex_mem_read   in   1       EX instruction is a load
//  branch_taken  in   1       EX resolved taken branch/jump (PC mux selects target)
//  mem_busy      in   1       data memory not ready this cycle
//  pc_en         out  1       PC register enable
//  if_id_en      out  1       IF_ID enable
//  if_id_flush   out  1       IF_ID flush (load NOP)
//  id_ex_en      out  1       ID_EX enable
//  id_ex_flush   out  1       ID_EX flush (insert bubble)
//  ex_mem_en     out  1       EX_MEM enable
//  mem_wb_flush  out  1       MEM_WB flush (bubble into WB)
//  mem_timeout   out  1       sticky: memory wait exceeded MAX_WAIT
//  stall_cycles  out  CNT_W   cycles with pc_en=0, saturating
//  flush_count   out  CNT_W   cycles with if_id_flush=1, saturating
// BEHAVIOUR
//  Control outputs combinational from state+inputs; state, wait_cnt, counters registered.
//  FSM: RUN, WAIT, TIMEOUT. Reset -> RUN, wait_cnt=0, counters=0, mem_timeout=0.
//  While rst=1: all *_en=1, all *_flush=0, mem_timeout=0, counters read 0.
//  load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
//  freeze = mem_busy | state==TIMEOUT. Priority: freeze > branch_taken > load_use > normal.
//  freeze: pc_en=if_id_en=id_ex_en=ex_mem_en=0, if_id_flush=id_ex_flush=0, mem_wb_flush=1;
//    branch_taken/load_use ignored (EX held, re-evaluated on release).
//  branch_taken: all en=1, if_id_flush=1, id_ex_flush=1, mem_wb_flush=0 (squash 2 wrong-path instr).
//  load_use: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1; exactly 1 bubble, clears naturally.
//  normal: all en=1, all flush=0.
//  FSM: RUN & mem_busy -> WAIT, wait_cnt<=1. WAIT & !mem_busy -> RUN, wait_cnt<=0.
//    WAIT & mem_busy: wait_cnt==MAX_WAIT -> TIMEOUT, else wait_cnt<=wait_cnt+1.
//    => MAX_WAIT consecutive busy cycles OK; MAX_WAIT+1 -> TIMEOUT on next edge.
//  TIMEOUT: mem_timeout=1, pipe frozen regardless of mem_busy; exits only on rst.
//  Counters: +1 on edge when counted condition true and rst=0; hold at 2^CNT_W-1 (no wrap).
//  rst mid-WAIT/TIMEOUT: next cycle RUN, wait_cnt=0, mem_timeout=0, counters 0.
// TESTING
//  ex_mem_read=1,ex_rd=5,id_rs1=5,used -> 1 cycle pc_en=0,if_id_en=0,id_ex_flush=1; stall_cycles=1.
//  Same with ex_rd=0 or rs1_used=0 -> no stall, all en=1.
//  branch_taken=1 with load_use=1 -> if_id_flush=id_ex_flush=1, pc_en=1; flush_count=1, stall_cycles=0.
//  MAX_WAIT=4: mem_busy 4 cycles then 0 -> frozen 4 cycles, mem_wb_flush=1, back to RUN, mem_timeout=0.
//  MAX_WAIT=4: mem_busy 5 cycles -> mem_timeout=1 after 5th edge, frozen after busy drops; rst clears.
//  CNT_W=3: hold stall 10 cycles -> stall_cycles saturates at 7; rst -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle between datapath and control
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              branch_taken;
    logic              mem_busy;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              ex_mem_en;
    logic              mem_wb_flush;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    // Datapath side: supplies hazard sources, consumes enables/flushes
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_flush, mem_timeout, stall_cycles, flush_count
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_flush, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/mem-wait hazard control for a 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]   WAIT_LIMIT = WCW'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t           state;
    logic [WCW-1:0]   wait_cnt;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic load_use;
    logic freeze;
    logic pc_en_c;
    logic if_id_en_c;
    logic if_id_flush_c;
    logic id_ex_en_c;
    logic id_ex_flush_c;
    logic ex_mem_en_c;
    logic mem_wb_flush_c;

    // Register x0 never carries a dependency, so a load into it cannot stall
    assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

    assign freeze = hz.mem_busy || (state == ST_TIMEOUT);

    // Prioritised stage control: freeze beats branch redirect beats load-use bubble
    always_comb begin
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b1;
        id_ex_flush_c  = 1'b0;
        ex_mem_en_c    = 1'b1;
        mem_wb_flush_c = 1'b0;
        if (rst) begin
            pc_en_c = 1'b1;
        end else if (freeze) begin
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_en_c     = 1'b0;
            ex_mem_en_c    = 1'b0;
            mem_wb_flush_c = 1'b1;
        end else if (hz.branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (load_use) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
        end
    end

    // Memory-wait FSM: counts consecutive busy cycles, latches a sticky timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hz.mem_busy) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!hz.mem_busy) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state     <= ST_TIMEOUT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_TIMEOUT: begin
                    timeout_q <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    wait_cnt  <= '0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters for stalled-PC and IF_ID-flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_c && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (if_id_flush_c && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.if_id_en     = if_id_en_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_en     = id_ex_en_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.ex_mem_en    = ex_mem_en_c;
    assign hz.mem_wb_flush = mem_wb_flush_c;
    assign hz.mem_timeout  = rst ? 1'b0 : timeout_q;
    assign hz.stall_cycles = rst ? '0 : stall_q;
    assign hz.flush_count  = rst ? '0 : flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(3)) hz ();

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(3), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_timeout}
    localparam logic [7:0] NORM = 8'b1101_0100;
    localparam logic [7:0] LU   = 8'b0001_1100;
    localparam logic [7:0] BR   = 8'b1111_1100;
    localparam logic [7:0] FRZ  = 8'b0000_0010;
    localparam logic [7:0] FRZT = 8'b0000_0011;

    typedef struct {
        string      name;
        logic [7:0] ctrl;
        logic [2:0] stall;
        logic [2:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Apply one cycle of inputs just after the rising edge and queue what must be seen
    task automatic step(input string nm, input bit r,
                        input int rs1, input bit u1, input int rs2, input bit u2,
                        input int exrd, input bit mr, input bit br, input bit busy,
                        input logic [7:0] c, input int st, input int fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        hz.id_rs1       = 5'(rs1);
        hz.id_rs1_used  = u1;
        hz.id_rs2       = 5'(rs2);
        hz.id_rs2_used  = u2;
        hz.ex_rd        = 5'(exrd);
        hz.ex_mem_read  = mr;
        hz.branch_taken = br;
        hz.mem_busy     = busy;
        e.name  = nm;
        e.ctrl  = c;
        e.stall = 3'(st);
        e.flush = 3'(fl);
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [7:0] c, input int st, input int fl);
        step(nm, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, c, st, fl);
    endtask

    task automatic reset_step(input string nm);
        step(nm, 1'b1, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b1, NORM, 0, 0);
    endtask

    // Monitor: outputs are stable mid-cycle, compare against the oldest expectation
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                       hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_flush, hz.mem_timeout};
                n_checks++;
                if (act === e.ctrl) n_pass++;
                else $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
                n_checks++;
                if (hz.stall_cycles === e.stall) n_pass++;
                else $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, hz.stall_cycles, e.stall);
                n_checks++;
                if (hz.flush_count === e.flush) n_pass++;
                else $display("FAIL %s flush_count: got %0d expected %0d", e.name, hz.flush_count, e.flush);
            end
        end
    end

    initial begin
        int guard;
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
        hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.branch_taken = 1'b0; hz.mem_busy = 1'b0;

        // Reset overrides any hazard on the inputs
        reset_step("rst_hold");
        idle("rst_release", NORM, 0, 0);

        // Load-use on rs1, then natural release
        step("lu_rs1", 1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, LU, 0, 0);
        idle("lu_rs1_after", NORM, 1, 0);
        step("lu_rd0", 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, NORM, 1, 0);
        step("lu_unused", 1'b0, 5, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, NORM, 1, 0);
        step("lu_rs2", 1'b0, 0, 1'b0, 7, 1'b1, 7, 1'b1, 1'b0, 1'b0, LU, 1, 0);
        idle("lu_rs2_after", NORM, 2, 0);

        // Branch beats load-use
        reset_step("rst_br");
        step("br_over_lu", 1'b0, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, BR, 0, 0);
        idle("br_after", NORM, 0, 1);

        // Four busy cycles (limit) then release, with a branch pending under freeze
        step("busy1_br", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, FRZ, 0, 1);
        step("busy2", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 1, 1);
        step("busy3", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 2, 1);
        step("busy4", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 3, 1);
        idle("busy_release", NORM, 4, 1);
        idle("run_again", NORM, 4, 1);

        // Five busy cycles -> sticky timeout, stall counter saturates at 7
        reset_step("rst_to");
        step("to_busy1", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 0, 0);
        step("to_busy2", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 1, 0);
        step("to_busy3", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 2, 0);
        step("to_busy4", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 3, 0);
        step("to_busy5", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 4, 0);
        step("to_br_ignored", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, FRZT, 5, 0);
        idle("to_held1", FRZT, 6, 0);
        idle("to_held2", FRZT, 7, 0);
        idle("to_sat", FRZT, 7, 0);
        reset_step("rst_clears_to");
        idle("to_cleared", NORM, 0, 0);

        // Held load-use: stall counter saturates at 2^3-1
        for (int i = 0; i < 10; i++)
            step($sformatf("lu_hold%0d", i), 1'b0, 9, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0,
                 LU, (i > 7) ? 7 : i, 0);
        idle("lu_hold_end", NORM, 7, 0);
        reset_step("rst_sat");
        idle("sat_cleared", NORM, 0, 0);

        // Reset in the middle of a memory wait
        step("mw_busy1", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 0, 0);
        step("mw_busy2", 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, FRZ, 1, 0);
        reset_step("mw_rst");
        idle("mw_run", NORM, 0, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
